// File: rtl/stream_merge_pkg.sv
// Shared types and constants for the stream merge arbiter.
// Optional feature macro: STREAM_MERGE_STATS_EN (per-port egress statistics).
package stream_merge_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int PORT_ID_W = 2;

  localparam logic [PORT_ID_W-1:0] PORT_1 = 2'd1;
  localparam logic [PORT_ID_W-1:0] PORT_2 = 2'd2;
  localparam logic [PORT_ID_W-1:0] PORT_3 = 2'd3;

  // Round-robin successor in the order 1 -> 2 -> 3 -> 1 (0 maps to 1).
  function automatic logic [PORT_ID_W-1:0] rr_next(input logic [PORT_ID_W-1:0] p);
    logic [PORT_ID_W-1:0] n;
    case (p)
      PORT_1:  n = PORT_2;
      PORT_2:  n = PORT_3;
      default: n = PORT_1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/stream_merge_arbiter_if.sv
// Handshake bundle for the stream merge arbiter: three ingress streams and
// one egress stream.
// Valid/ready: a beat transfers on a rising clk edge where valid && ready;
// once valid is high the source holds data (and id/last) stable and keeps
// valid high until that transfer happens.
interface stream_merge_arbiter_if #(parameter int DATA_WIDTH = 64);

  logic [DATA_WIDTH-1:0] in_axi_data_1;
  logic                  in_axi_valid_1;
  logic                  in_axi_ready_1;
  logic [DATA_WIDTH-1:0] in_axi_data_2;
  logic                  in_axi_valid_2;
  logic                  in_axi_ready_2;
  logic [DATA_WIDTH-1:0] in_axi_data_3;
  logic                  in_axi_valid_3;
  logic                  in_axi_ready_3;

  logic [DATA_WIDTH-1:0]                   m_axi_data;
  logic [stream_merge_pkg::PORT_ID_W-1:0]  m_axi_id;
  logic                                    m_axi_last;
  logic                                    m_axi_valid;
  logic                                    m_axi_ready;

  // Arbiter side: sinks the three ingress streams, sources the egress stream.
  modport slave (
    input  in_axi_data_1, in_axi_valid_1,
    output in_axi_ready_1,
    input  in_axi_data_2, in_axi_valid_2,
    output in_axi_ready_2,
    input  in_axi_data_3, in_axi_valid_3,
    output in_axi_ready_3,
    output m_axi_data, m_axi_id, m_axi_last, m_axi_valid,
    input  m_axi_ready
  );

  // Environment side: sources the ingress streams, sinks the egress stream.
  modport master (
    output in_axi_data_1, in_axi_valid_1,
    input  in_axi_ready_1,
    output in_axi_data_2, in_axi_valid_2,
    input  in_axi_ready_2,
    output in_axi_data_3, in_axi_valid_3,
    input  in_axi_ready_3,
    input  m_axi_data, m_axi_id, m_axi_last, m_axi_valid,
    output m_axi_ready
  );

endinterface

// File: rtl/stream_merge_fifo.sv
// Per-port ingress FIFO: push via valid/ready, pop strobe from the arbiter,
// registered occupancy count and registered not-full (in_ready).
module stream_merge_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_next;
  logic                  push;
  logic                  pop_ok;

  assign push     = in_valid && in_ready;
  assign pop_ok   = pop && (count != '0);
  assign out_data = mem[rd_ptr];

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop_ok})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Pointers, count and the registered not-full flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      count    <= count_next;
      in_ready <= (count_next < CW'(DEPTH));
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/stream_merge_arbiter.sv
// Three-input stream merge: per-port FIFOs, round-robin burst arbiter and a
// single egress register stage. Each egress beat carries its source port id
// and an end-of-burst flag.
// Optional feature macro: STREAM_MERGE_STATS_EN adds per-port beat counters
// and a saturating egress stall counter.
module stream_merge_arbiter
  import stream_merge_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  stream_merge_arbiter_if.slave bus,
  output arb_state_t dbg_state
`ifdef STREAM_MERGE_STATS_EN
  ,
  output logic [31:0] stat_beats_1,
  output logic [31:0] stat_beats_2,
  output logic [31:0] stat_beats_3,
  output logic [31:0] stat_stall
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(MAX_BURST) + 1;

  logic [DATA_WIDTH-1:0] f_data [3];
  logic [CW-1:0]         f_cnt  [3];
  logic [2:0]            f_pop;
  logic [2:0]            nonempty;

  arb_state_t            state;
  arb_state_t            state_next;
  logic [PORT_ID_W-1:0]  grant_id;
  logic [PORT_ID_W-1:0]  last_grant;
  logic [BW-1:0]         beat_cnt;

  logic [PORT_ID_W-1:0]  scan_o0;
  logic [PORT_ID_W-1:0]  scan_o1;
  logic [PORT_ID_W-1:0]  scan_o2;
  logic [PORT_ID_W-1:0]  scan_id;
  logic                  scan_hit;

  logic                  egress_free;
  logic                  load;
  logic                  load_last;
  logic [CW-1:0]         sel_cnt;
  logic [DATA_WIDTH-1:0] sel_data;

  logic [DATA_WIDTH-1:0] m_data_q;
  logic [PORT_ID_W-1:0]  m_id_q;
  logic                  m_last_q;
  logic                  m_valid_q;

  stream_merge_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_1 (
    .clk(clk), .reset_n(reset_n),
    .in_data(bus.in_axi_data_1), .in_valid(bus.in_axi_valid_1), .in_ready(bus.in_axi_ready_1),
    .pop(f_pop[0]), .out_data(f_data[0]), .count(f_cnt[0])
  );

  stream_merge_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_2 (
    .clk(clk), .reset_n(reset_n),
    .in_data(bus.in_axi_data_2), .in_valid(bus.in_axi_valid_2), .in_ready(bus.in_axi_ready_2),
    .pop(f_pop[1]), .out_data(f_data[1]), .count(f_cnt[1])
  );

  stream_merge_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_3 (
    .clk(clk), .reset_n(reset_n),
    .in_data(bus.in_axi_data_3), .in_valid(bus.in_axi_valid_3), .in_ready(bus.in_axi_ready_3),
    .pop(f_pop[2]), .out_data(f_data[2]), .count(f_cnt[2])
  );

  assign nonempty    = {f_cnt[2] != '0, f_cnt[1] != '0, f_cnt[0] != '0};
  assign egress_free = !m_valid_q || bus.m_axi_ready;
  assign dbg_state   = state;

  assign bus.m_axi_data  = m_data_q;
  assign bus.m_axi_id    = m_id_q;
  assign bus.m_axi_last  = m_last_q;
  assign bus.m_axi_valid = m_valid_q;

  // Round-robin scan from the port after last_grant over registered counts.
  always_comb begin
    scan_o0  = rr_next(last_grant);
    scan_o1  = rr_next(scan_o0);
    scan_o2  = rr_next(scan_o1);
    scan_hit = 1'b1;
    scan_id  = scan_o0;
    if (nonempty[scan_o0 - 2'd1])      scan_id = scan_o0;
    else if (nonempty[scan_o1 - 2'd1]) scan_id = scan_o1;
    else if (nonempty[scan_o2 - 2'd1]) scan_id = scan_o2;
    else                               scan_hit = 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARB_IDLE;
    else          state <= state_next;
  end

  // FSM next state: a grant ends on the edge that loads its last beat.
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:  if (scan_hit) state_next = ARB_GRANT;
      ARB_GRANT: if (load && load_last) state_next = ARB_IDLE;
      default:   state_next = ARB_IDLE;
    endcase
  end

  // FSM outputs: pop the granted FIFO into the egress register when it is free.
  always_comb begin
    sel_cnt  = '0;
    sel_data = '0;
    case (grant_id)
      PORT_1:  begin sel_cnt = f_cnt[0]; sel_data = f_data[0]; end
      PORT_2:  begin sel_cnt = f_cnt[1]; sel_data = f_data[1]; end
      PORT_3:  begin sel_cnt = f_cnt[2]; sel_data = f_data[2]; end
      default: begin sel_cnt = '0;       sel_data = '0;        end
    endcase
    load      = (state == ARB_GRANT) && egress_free && (sel_cnt != '0);
    // A push landing in the same cycle is not visible in sel_cnt, so it
    // cannot extend a burst that is already ending.
    load_last = (beat_cnt == BW'(MAX_BURST - 1)) || (sel_cnt == CW'(1));
    f_pop     = load ? (3'b001 << (grant_id - 2'd1)) : 3'b000;
  end

  // Grant bookkeeping: capture the winner and count beats within the burst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_id   <= PORT_1;
      last_grant <= PORT_3;
      beat_cnt   <= '0;
    end else if (state == ARB_IDLE && scan_hit) begin
      grant_id   <= scan_id;
      last_grant <= scan_id;
      beat_cnt   <= '0;
    end else if (load) begin
      beat_cnt   <= beat_cnt + BW'(1);
    end
  end

  // Egress register: holds while stalled, reloads or empties when free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data_q  <= '0;
      m_id_q    <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else if (egress_free) begin
      if (load) begin
        m_data_q  <= sel_data;
        m_id_q    <= grant_id;
        m_last_q  <= load_last;
        m_valid_q <= 1'b1;
      end else begin
        m_valid_q <= 1'b0;
      end
    end
  end

`ifdef STREAM_MERGE_STATS_EN
  // Egress statistics: wrapping per-port beat counts, saturating stall count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_beats_1 <= '0;
      stat_beats_2 <= '0;
      stat_beats_3 <= '0;
      stat_stall   <= '0;
    end else begin
      if (m_valid_q && bus.m_axi_ready) begin
        case (m_id_q)
          PORT_1:  stat_beats_1 <= stat_beats_1 + 32'd1;
          PORT_2:  stat_beats_2 <= stat_beats_2 + 32'd1;
          PORT_3:  stat_beats_3 <= stat_beats_3 + 32'd1;
          default: ;
        endcase
      end
      if (m_valid_q && !bus.m_axi_ready && (stat_stall != 32'hFFFF_FFFF))
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_merge_arbiter.sv
// Self-checking bench for stream_merge_arbiter: randomized payloads checked
// against a round-robin burst model and per-port ordering scoreboard.
// Build with STREAM_MERGE_STATS_EN defined to also check the statistics ports.
module tb_stream_merge_arbiter;
  import stream_merge_pkg::*;

  localparam int DW = 64;
  localparam int FD = 16;
  localparam int MB = 8;

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          last;
    int            c;
  } beat_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_merge_arbiter_if #(.DATA_WIDTH(DW)) bus ();
  arb_state_t dbg_state;
`ifdef STREAM_MERGE_STATS_EN
  logic [31:0] stat_beats_1, stat_beats_2, stat_beats_3, stat_stall;
`endif

  stream_merge_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .MAX_BURST(MB)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave),
    .dbg_state(dbg_state)
`ifdef STREAM_MERGE_STATS_EN
    ,
    .stat_beats_1(stat_beats_1),
    .stat_beats_2(stat_beats_2),
    .stat_beats_3(stat_beats_3),
    .stat_stall(stat_stall)
`endif
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            passes = 0;
  int            stall_model = 0;
  beat_t         cap_q[$];
  beat_t         mb;
  logic [DW+2:0] exp_q[$];   // {id[1:0], last, data}
  logic [DW-1:0] src_q1[$], src_q2[$], src_q3[$];

  // Egress monitor: records each handshake and counts stalled cycles.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.m_axi_valid && bus.m_axi_ready) begin
        mb.id = bus.m_axi_id; mb.data = bus.m_axi_data; mb.last = bus.m_axi_last; mb.c = cyc;
        cap_q.push_back(mb);
      end
      if (bus.m_axi_valid && !bus.m_axi_ready) stall_model++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passes);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input int p, input logic [DW-1:0] d, input logic v);
    case (p)
      1: begin bus.in_axi_data_1 = d; bus.in_axi_valid_1 = v; end
      2: begin bus.in_axi_data_2 = d; bus.in_axi_valid_2 = v; end
      default: begin bus.in_axi_data_3 = d; bus.in_axi_valid_3 = v; end
    endcase
  endtask

  function automatic logic get_ready(input int p);
    case (p)
      1: return bus.in_axi_ready_1;
      2: return bus.in_axi_ready_2;
      default: return bus.in_axi_ready_3;
    endcase
  endfunction

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic push_beat(input int p, input logic [DW-1:0] d, output bit ok, output int acc_cyc);
    logic r;
    ok = 1'b0;
    acc_cyc = -1;
    set_in(p, d, 1'b1);
    for (int t = 0; t < 500 && !ok; t++) begin
      r = get_ready(p);
      @(posedge clk); #1;
      if (r) begin ok = 1'b1; acc_cyc = cyc; end
    end
    set_in(p, '0, 1'b0);
  endtask

  task automatic wait_cap(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      if (cap_q.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (cap_q.size() >= n) ok = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int p = 1; p <= 3; p++) set_in(p, '0, 1'b0);
    bus.m_axi_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cap_q.delete();
    exp_q.delete();
    src_q1.delete(); src_q2.delete(); src_q3.delete();
    stall_model = 0;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int qsize(input int p);
    case (p)
      1: return src_q1.size();
      2: return src_q2.size();
      default: return src_q3.size();
    endcase
  endfunction

  function automatic logic [DW-1:0] qpop(input int p);
    case (p)
      1: return src_q1.pop_front();
      2: return src_q2.pop_front();
      default: return src_q3.pop_front();
    endcase
  endfunction

  function automatic logic [DW-1:0] qat(input int p, input int i);
    case (p)
      1: return src_q1[i];
      2: return src_q2[i];
      default: return src_q3[i];
    endcase
  endfunction

  // Fully buffered ports: serve ports in 1,2,3 rotation after the previous
  // winner, each for min(MAX_BURST, beats left) beats. Consumes src queues.
  task automatic build_rr();
    int last_p, p, n;
    logic [DW-1:0] d;
    exp_q.delete();
    last_p = 3;
    while (src_q1.size() + src_q2.size() + src_q3.size() > 0) begin
      p = last_p;
      for (int k = 0; k < 3; k++) begin
        p = (p % 3) + 1;
        if (qsize(p) > 0) break;
      end
      n = (qsize(p) < MB) ? qsize(p) : MB;
      for (int i = 0; i < n; i++) begin
        d = qpop(p);
        exp_q.push_back({2'(p), (i == n - 1), d});
      end
      last_p = p;
    end
  endtask

  task automatic push_all(input int p);
    bit ok; int ac;
    for (int i = 0; i < qsize(p); i++) begin
      push_beat(p, qat(p, i), ok, ac);
      checks++;
      if (!ok) $display("FAIL push_p%0d_beat%0d: accepted=0 required=1", p, i);
      else passes++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    bus.m_axi_ready = 1'b1;
    for (int p = 1; p <= 3; p++) set_in(p, DW'(64'hA5A5_0000_0000_0000 + 64'(p)), 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.m_axi_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.m_axi_valid); else passes++;
    checks++; if (bus.m_axi_data !== '0) $display("FAIL reset_data: got %h want 0", bus.m_axi_data); else passes++;
    checks++; if (bus.m_axi_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", bus.m_axi_id); else passes++;
    checks++; if (bus.m_axi_last !== 1'b0) $display("FAIL reset_last: got %b want 0", bus.m_axi_last); else passes++;
    checks++;
    if ({bus.in_axi_ready_3, bus.in_axi_ready_2, bus.in_axi_ready_1} !== 3'b000)
      $display("FAIL reset_in_ready: got %b want 000", {bus.in_axi_ready_3, bus.in_axi_ready_2, bus.in_axi_ready_1});
    else passes++;
    for (int p = 1; p <= 3; p++) set_in(p, '0, 1'b0);
    reset_n = 1'b1;
    #1;
    checks++;
    if ({bus.in_axi_ready_3, bus.in_axi_ready_2, bus.in_axi_ready_1} !== 3'b000)
      $display("FAIL release_in_ready_before_edge: got %b want 000", {bus.in_axi_ready_3, bus.in_axi_ready_2, bus.in_axi_ready_1});
    else passes++;
    @(posedge clk); #1;
    checks++;
    if ({bus.in_axi_ready_3, bus.in_axi_ready_2, bus.in_axi_ready_1} !== 3'b111)
      $display("FAIL release_in_ready_after_edge: got %b want 111", {bus.in_axi_ready_3, bus.in_axi_ready_2, bus.in_axi_ready_1});
    else passes++;
  endtask

  task automatic test_latency();
    bit ok; int a0, ac;
    logic [DW-1:0] d [3];
    do_reset();
    bus.m_axi_ready = 1'b1;
    for (int i = 0; i < 3; i++) d[i] = {$urandom(), $urandom()};
    push_beat(2, d[0], ok, a0);
    push_beat(2, d[1], ok, ac);
    push_beat(2, d[2], ok, ac);
    wait_cap(3, 50, ok);
    checks++;
    if (!ok || cap_q.size() != 3) $display("FAIL lat_count: got %0d beats want 3", cap_q.size());
    else begin
      passes++;
      checks++;
      if (cap_q[0].c !== a0 + 2) $display("FAIL lat_first_valid: got cycle %0d want %0d", cap_q[0].c, a0 + 2);
      else passes++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cap_q[i].id !== 2'd2 || cap_q[i].data !== d[i] || cap_q[i].last !== (i == 2))
          $display("FAIL lat_beat%0d: got id=%0d data=%h last=%b want id=2 data=%h last=%b",
                   i, cap_q[i].id, cap_q[i].data, cap_q[i].last, d[i], (i == 2));
        else passes++;
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok; int gap_want;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      src_q1.push_back({$urandom(), $urandom()});
      src_q2.push_back({$urandom(), $urandom()});
      src_q3.push_back({$urandom(), $urandom()});
    end
    push_all(1); push_all(2); push_all(3);
    build_rr();
    bus.m_axi_ready = 1'b1;
    wait_cap(exp_q.size(), 300, ok);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (cap_q.size() != exp_q.size()) $display("FAIL rr_count: got %0d beats want %0d", cap_q.size(), exp_q.size());
    else begin
      passes++;
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (cap_q[i].id !== exp_q[i][DW+2:DW+1] || cap_q[i].last !== exp_q[i][DW] || cap_q[i].data !== exp_q[i][DW-1:0])
          $display("FAIL rr_beat%0d: got id=%0d last=%b data=%h want id=%0d last=%b data=%h", i,
                   cap_q[i].id, cap_q[i].last, cap_q[i].data, exp_q[i][DW+2:DW+1], exp_q[i][DW], exp_q[i][DW-1:0]);
        else passes++;
        if (i > 0) begin
          gap_want = exp_q[i-1][DW] ? 2 : 1;
          checks++;
          if (cap_q[i].c - cap_q[i-1].c != gap_want)
            $display("FAIL rr_gap%0d: got %0d cycles want %0d", i, cap_q[i].c - cap_q[i-1].c, gap_want);
          else passes++;
        end
      end
    end
`ifdef STREAM_MERGE_STATS_EN
    checks++; if (stat_beats_1 !== 32'd10) $display("FAIL stat_beats_1: got %0d want 10", stat_beats_1); else passes++;
    checks++; if (stat_beats_2 !== 32'd10) $display("FAIL stat_beats_2: got %0d want 10", stat_beats_2); else passes++;
    checks++; if (stat_beats_3 !== 32'd10) $display("FAIL stat_beats_3: got %0d want 10", stat_beats_3); else passes++;
    checks++; if (stat_stall !== 32'(stall_model)) $display("FAIL stat_stall: got %0d want %0d", stat_stall, stall_model); else passes++;
`endif
  endtask

  // FIFO capacity plus the one beat already moved into the egress register.
  task automatic test_full();
    bit ok; int ac; int n_acc; bit rdy_seen;
    logic [DW-1:0] d [FD + 2];
    do_reset();
    for (int i = 0; i < FD + 2; i++) d[i] = {$urandom(), $urandom()};
    n_acc = 0;
    for (int i = 0; i < FD + 1; i++) begin
      push_beat(1, d[i], ok, ac);
      if (ok) n_acc++;
    end
    checks++;
    if (n_acc != FD + 1) $display("FAIL full_accepted: got %0d want %0d", n_acc, FD + 1); else passes++;
    checks++;
    if (bus.in_axi_ready_1 !== 1'b0) $display("FAIL full_ready_drop: got %b want 0", bus.in_axi_ready_1); else passes++;
    set_in(1, d[FD + 1], 1'b1);
    rdy_seen = 1'b0;
    for (int t = 0; t < 6; t++) begin
      if (bus.in_axi_ready_1 !== 1'b0) rdy_seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (rdy_seen) $display("FAIL full_stalled_beat: ready seen=1 want 0"); else passes++;
    bus.m_axi_ready = 1'b1;
    push_beat(1, d[FD + 1], ok, ac);
    checks++;
    if (!ok) $display("FAIL full_late_accept: accepted=0 want 1"); else passes++;
    wait_cap(FD + 2, 200, ok);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (cap_q.size() != FD + 2) $display("FAIL full_count: got %0d want %0d", cap_q.size(), FD + 2);
    else begin
      passes++;
      for (int i = 0; i < FD + 2; i++) begin
        checks++;
        if (cap_q[i].id !== 2'd1 || cap_q[i].data !== d[i])
          $display("FAIL full_beat%0d: got id=%0d data=%h want id=1 data=%h", i, cap_q[i].id, cap_q[i].data, d[i]);
        else passes++;
      end
    end
  endtask

  task automatic test_random_stall();
    bit ok; bit stalled_prev; int n;
    logic [DW-1:0] s_data; logic [1:0] s_id; logic s_last;
    do_reset();
    for (int p = 1; p <= 3; p++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        case (p)
          1: src_q1.push_back({$urandom(), $urandom()});
          2: src_q2.push_back({$urandom(), $urandom()});
          default: src_q3.push_back({$urandom(), $urandom()});
        endcase
      end
    end
    push_all(1); push_all(2); push_all(3);
    build_rr();
    stalled_prev = 1'b0;
    s_data = '0; s_id = '0; s_last = 1'b0;
    for (int t = 0; t < 2000 && cap_q.size() < exp_q.size(); t++) begin
      if (stalled_prev) begin
        checks++;
        if (bus.m_axi_valid !== 1'b1 || bus.m_axi_data !== s_data || bus.m_axi_id !== s_id || bus.m_axi_last !== s_last)
          $display("FAIL stall_hold_cyc%0d: got v=%b id=%0d last=%b data=%h want v=1 id=%0d last=%b data=%h", cyc,
                   bus.m_axi_valid, bus.m_axi_id, bus.m_axi_last, bus.m_axi_data, s_id, s_last, s_data);
        else passes++;
      end
      bus.m_axi_ready = 1'($urandom_range(0, 1));
      stalled_prev = bus.m_axi_valid && !bus.m_axi_ready;
      s_data = bus.m_axi_data; s_id = bus.m_axi_id; s_last = bus.m_axi_last;
      @(posedge clk); #1;
    end
    bus.m_axi_ready = 1'b1;
    wait_cap(exp_q.size(), 100, ok);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (cap_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d beats want %0d", cap_q.size(), exp_q.size());
    else begin
      passes++;
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (cap_q[i].id !== exp_q[i][DW+2:DW+1] || cap_q[i].last !== exp_q[i][DW] || cap_q[i].data !== exp_q[i][DW-1:0])
          $display("FAIL rand_beat%0d: got id=%0d last=%b data=%h want id=%0d last=%b data=%h", i,
                   cap_q[i].id, cap_q[i].last, cap_q[i].data, exp_q[i][DW+2:DW+1], exp_q[i][DW], exp_q[i][DW-1:0]);
        else passes++;
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok; int ac;
    logic [DW-1:0] d1, d3;
    do_reset();
    for (int i = 0; i < 5; i++) push_beat(2, {$urandom(), $urandom()}, ok, ac);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.m_axi_valid !== 1'b0 || bus.m_axi_data !== '0 || bus.m_axi_id !== 2'd0 || bus.m_axi_last !== 1'b0)
      $display("FAIL midrst_outputs: got v=%b id=%0d last=%b data=%h want all 0",
               bus.m_axi_valid, bus.m_axi_id, bus.m_axi_last, bus.m_axi_data);
    else passes++;
    checks++;
    if ({bus.in_axi_ready_3, bus.in_axi_ready_2, bus.in_axi_ready_1} !== 3'b000)
      $display("FAIL midrst_in_ready: got %b want 000", {bus.in_axi_ready_3, bus.in_axi_ready_2, bus.in_axi_ready_1});
    else passes++;
    repeat (2) @(posedge clk);
    #1;
    cap_q.delete();
    stall_model = 0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    bus.m_axi_ready = 1'b1;
    d1 = {$urandom(), $urandom()};
    d3 = {$urandom(), $urandom()};
    set_in(1, d1, 1'b1);
    set_in(3, d3, 1'b1);
    @(posedge clk); #1;
    set_in(1, '0, 1'b0);
    set_in(3, '0, 1'b0);
    wait_cap(2, 50, ok);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (cap_q.size() != 2) $display("FAIL midrst_count: got %0d beats want 2", cap_q.size());
    else begin
      passes++;
      checks++;
      if (cap_q[0].id !== 2'd1 || cap_q[0].data !== d1)
        $display("FAIL midrst_first_grant: got id=%0d data=%h want id=1 data=%h", cap_q[0].id, cap_q[0].data, d1);
      else passes++;
      checks++;
      if (cap_q[1].id !== 2'd3 || cap_q[1].data !== d3)
        $display("FAIL midrst_second_grant: got id=%0d data=%h want id=3 data=%h", cap_q[1].id, cap_q[1].data, d3);
      else passes++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.m_axi_ready = 1'b0;
    for (int p = 1; p <= 3; p++) set_in(p, '0, 1'b0);
    test_reset();
    test_latency();
    test_round_robin();
    test_full();
    test_random_stall();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
